// File: rtl/reg_load_arbiter_pkg.sv
// Shared types and constants for the operand-register load arbiter.
// The FSM states and the operand pipeline depth live here.
package reg_load_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN1,
    DRAIN2
  } state_e;

  localparam int OPND_PIPE_LAT  = 2;
  localparam int DEF_DATA_WIDTH = 32;

  // Cycles spent in DRAIN1 before the final DRAIN2 cycle.
  localparam int DRAIN1_CYC = OPND_PIPE_LAT - 1;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Round-robin winner search: first valid bit at or above ptr_i,
// wrapping modulo N; result is one-hot (all zeros if nothing valid).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic          found;
  logic [IW-1:0] idx;
  int            sum;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr_i) + k;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Arbitrates requester loads into a pipelined operand register and
// signals completion once the value reaches the register output.
module reg_load_arbiter
  import reg_load_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          load_a,
  output logic [DATA_WIDTH-1:0]         data_in_a,
  output logic                          rsp_valid,
  output logic [IW-1:0]                 rsp_id,
  output logic                          busy
);

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         win_idx;
  logic [DATA_WIDTH-1:0] win_data;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx  = IW'(i);
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    load_a    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = reset ? '0 : grant;
        if (|grant) begin
          id_d    = win_idx;
          data_d  = win_data;
          ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_a  = 1'b1;
        cnt_d   = CNT_W'(DRAIN1_CYC - 1);
        state_d = DRAIN1;
      end
      DRAIN1: begin
        if (cnt_q == '0) state_d = DRAIN2;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DRAIN2: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_in_a = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule
